// File: rtl/sdf_fft_pkg.sv
// Shared constants and helpers for the SDF FFT pipeline: default frame size,
// sample width and the bit-reversal used to map stage output order to natural order.
package sdf_fft_pkg;

  localparam int NFFT_DEF   = 64;
  localparam int DATA_W_DEF = 16;
  localparam int LOG2N      = $clog2(NFFT_DEF);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = idx[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_pingpong_ram.sv
// Two-bank frame store: one synchronous write port and one asynchronous read port,
// each selecting its own bank so one frame can fill while the other drains.
module sdf_pingpong_ram #(
  parameter int NFFT  = 64,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(NFFT)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Storage is intentionally not reset; contents are don't-care until written.
  logic [WIDTH-1:0] mem [2*NFFT];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/sdf_bitrev_reorder_buffer.sv
// Collects each bit-reversed frame from the last SDF stage and re-emits it in natural
// order through a registered valid/ready output, ping-ponging between two banks.
module sdf_bitrev_reorder_buffer
  import sdf_fft_pkg::*;
#(
  parameter int NFFT   = NFFT_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_last
);

  localparam int CNT_W = $clog2(NFFT);

  if (NFFT < 4 || (NFFT & (NFFT - 1)) != 0) begin : g_bad_nfft
    $error("sdf_bitrev_reorder_buffer: NFFT must be a power of two and at least 4");
  end

  logic [CNT_W-1:0]    wr_cnt;
  logic [CNT_W-1:0]    rd_cnt;
  logic [CNT_W-1:0]    wr_addr;
  logic                wr_bank;
  logic                rd_bank;
  logic [1:0]          bank_full;
  logic [1:0]          bank_full_nxt;
  logic                wr_fire;
  logic                wr_wrap;
  logic                rd_load;
  logic                rd_wrap;
  logic [2*DATA_W-1:0] rd_data;

  // Bit-reverse the write counter locally so any power-of-two NFFT works.
  always_comb begin
    wr_addr = '0;
    for (int i = 0; i < CNT_W; i++) begin
      wr_addr[i] = wr_cnt[CNT_W-1-i];
    end
  end

  assign in_ready = !bank_full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign wr_wrap  = wr_fire && (wr_cnt == CNT_W'(NFFT - 1));
  assign rd_load  = bank_full[rd_bank] && (!out_valid || out_ready);
  assign rd_wrap  = rd_load && (rd_cnt == CNT_W'(NFFT - 1));

  // Writer and reader always work on different banks, so set and clear never collide.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_wrap) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
    if (rd_wrap) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
  end

  sdf_pingpong_ram #(
    .NFFT  (NFFT),
    .WIDTH (2 * DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data ({in_re, in_im}),
    .rd_bank (rd_bank),
    .rd_addr (rd_cnt),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
        if (wr_wrap) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (rd_load) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
        if (rd_wrap) begin
          rd_bank <= ~rd_bank;
        end
      end
    end
  end

  // Output register: reloads on every accepted beat, holds data when idle or stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
    end else if (rd_load) begin
      out_valid <= 1'b1;
      out_re    <= rd_data[2*DATA_W-1:DATA_W];
      out_im    <= rd_data[DATA_W-1:0];
      out_last  <= (rd_cnt == CNT_W'(NFFT - 1));
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdf_bitrev_reorder_buffer.sv
// Scoreboard bench for the bit-reverse reorder buffer: frames are driven in
// bit-reversed order and compared against their natural-order expectation.
module tb_sdf_bitrev_reorder_buffer;
  import sdf_fft_pkg::*;

  localparam int N = 64;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic         out_last;

  always #5 clk = ~clk;

  sdf_bitrev_reorder_buffer #(.NFFT(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last)
  );

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_pct = 0;
  int hs_cnt = 0;
  int valid_cnt = 0;
  int first_valid = -1;
  int last_valid = -1;
  int last_in_cyc = -1;
  logic         stall = 1'b0;
  logic [W-1:0] s_re, s_im;
  logic         s_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Output side: drives out_ready, checks stall stability and pops the scoreboard.
  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        tests++;
        if (out_valid !== 1'b1 || out_re !== s_re || out_im !== s_im || out_last !== s_last) begin
          fails++;
          $display("FAIL stall_hold: got v=%b re=%h im=%h last=%b, need v=1 re=%h im=%h last=%b",
                   out_valid, out_re, out_im, out_last, s_re, s_im, s_last);
        end
      end
      if (out_valid === 1'b1) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      stall  = out_valid && !out_ready;
      s_re   = out_re;
      s_im   = out_im;
      s_last = out_last;
      if (out_valid && out_ready) begin
        hs_cnt++;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL extra_output: got re=%h im=%h with no sample expected", out_re, out_im);
        end else begin
          e = q.pop_front();
          if (out_re !== e.re || out_im !== e.im || out_last !== e.last) begin
            fails++;
            $display("FAIL sample: got re=%h im=%h last=%b, need re=%h im=%h last=%b",
                     out_re, out_im, out_last, e.re, e.im, e.last);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && in_ready && dut.bank_full[dut.wr_bank]) begin
      fails++;
      $display("FAIL write_into_busy_bank: in_ready=%b while bank %0d is full", in_ready, dut.wr_bank);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    hs_cnt = 0;
    valid_cnt = 0;
    first_valid = -1;
    last_valid = -1;
  endtask

  // Frame f carries natural index n as re = f*N+n, im = ~re; driven in bit-reversed order.
  task automatic drive_frame(input int f, input int npts, input int vpct);
    int k = 0;
    int guard = 0;
    logic [LOG2N-1:0] n;
    if (npts == N) begin
      for (int i = 0; i < N; i++) begin
        q.push_back('{re: W'(f * N + i), im: ~W'(f * N + i), last: (i == N - 1)});
      end
    end
    while (k < npts && guard < 20000) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) < vpct);
      n = bitrev(LOG2N'(k));
      in_re = W'(f * N + int'(n));
      in_im = ~in_re;
      if (in_valid && in_ready) begin
        k++;
        last_in_cyc = cyc;
      end
      guard++;
    end
    tests++;
    if (k != npts) begin
      fails++;
      $display("FAIL drive_timeout: accepted %0d of %0d samples of frame %0d", k, npts, f);
    end
  endtask

  task automatic stop_input();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int guard = 0;
    while (q.size() != 0 && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d samples still expected, need 0", q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    ready_pct = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    tests++;
    if (out_re !== '0 || out_im !== '0) begin fails++; $display("FAIL reset_data: got re=%h im=%h need 0", out_re, out_im); end
    tests++;
    if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b need 0", out_last); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
  endtask

  task automatic test_single_frame();
    clear_counts();
    ready_pct = 100;
    drive_frame(0, N, 100);
    stop_input();
    wait_drain(500);
    tests++;
    if (first_valid - last_in_cyc != 2) begin
      fails++;
      $display("FAIL latency: got %0d cycles need 2", first_valid - last_in_cyc);
    end
    tests++;
    if (hs_cnt != N || valid_cnt != N) begin
      fails++;
      $display("FAIL single_count: got hs=%0d valid=%0d need %0d", hs_cnt, valid_cnt, N);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    ready_pct = 100;
    drive_frame(1, N, 100);
    drive_frame(2, N, 100);
    drive_frame(3, N, 100);
    stop_input();
    wait_drain(1000);
    tests++;
    if (valid_cnt != 3 * N || last_valid - first_valid != 3 * N - 1) begin
      fails++;
      $display("FAIL b2b_gaps: got valid=%0d span=%0d need %0d and %0d",
               valid_cnt, last_valid - first_valid, 3 * N, 3 * N - 1);
    end
    tests++;
    if (hs_cnt != 3 * N) begin fails++; $display("FAIL b2b_count: got %0d need %0d", hs_cnt, 3 * N); end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int guard = 0;
    bit seen = 0;
    clear_counts();
    ready_pct = 0;
    drive_frame(4, N, 100);
    drive_frame(5, N, 100);
    repeat (20) begin
      @(negedge clk);
      in_valid = 1'b1;
      if (in_ready) accepted++;
    end
    tests++;
    if (accepted != 0) begin fails++; $display("FAIL full_accept: got %0d extra samples need 0", accepted); end
    tests++;
    if (out_valid !== 1'b1 || out_re !== W'(4 * N) || out_im !== ~W'(4 * N)) begin
      fails++;
      $display("FAIL frozen_output: got v=%b re=%h need v=1 re=%h", out_valid, out_re, W'(4 * N));
    end
    in_valid = 1'b0;
    ready_pct = 100;
    while (!seen && guard < 300) begin
      @(negedge clk);
      if (in_ready) seen = 1;
      guard++;
    end
    tests++;
    if (!seen || out_re !== W'(4 * N + N - 1) || out_last !== 1'b1) begin
      fails++;
      $display("FAIL ready_return: got seen=%0d re=%h last=%b need seen=1 re=%h last=1",
               seen, out_re, out_last, W'(4 * N + N - 1));
    end
    wait_drain(500);
    tests++;
    if (hs_cnt != 2 * N) begin fails++; $display("FAIL bp_count: got %0d need %0d", hs_cnt, 2 * N); end
  endtask

  task automatic test_random();
    clear_counts();
    ready_pct = 50;
    for (int f = 0; f < 10; f++) begin
      drive_frame(10 + f, N, 50);
    end
    stop_input();
    wait_drain(5000);
    tests++;
    if (hs_cnt != 10 * N) begin fails++; $display("FAIL random_count: got %0d need %0d", hs_cnt, 10 * N); end
  endtask

  task automatic test_reset_midframe();
    ready_pct = 100;
    drive_frame(20, N, 100);
    drive_frame(21, N, 100);
    drive_frame(22, 20, 100);
    @(posedge clk);
    #2;
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_valid: got %b need 1", out_valid); end
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL midreset_ctrl: got v=%b last=%b need 0 0", out_valid, out_last);
    end
    tests++;
    if (out_re !== '0 || out_im !== '0) begin fails++; $display("FAIL midreset_data: got re=%h im=%h need 0", out_re, out_im); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_in_ready: got %b need 1", in_ready); end
    q.delete();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_counts();
    drive_frame(23, N, 100);
    stop_input();
    wait_drain(500);
    tests++;
    if (hs_cnt != N) begin fails++; $display("FAIL post_reset_count: got %0d need %0d", hs_cnt, N); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
